// File: rtl/wh_bram_writer.sv
// wh_bram_writer
// Write side of the WH BRAM. It accepts a stream of WH feature vectors and
// tags each one with its sub-graph node count and a sub-graph-start flag.
// Each tagged vector is packed into one BRAM word and written on port a, at
// consecutive addresses starting from 0 for every pass.
// Optional feature: define WB_STATS_EN to add the wb_subgraph_cnt_o output,
// which counts the sub-graph start beats of the current pass.
module wh_bram_writer #(
   parameter int DATA_WIDTH      = 8,
   parameter int NUM_FEATURES    = 16,
   parameter int BRAM_ADDR_WIDTH = 32,
   parameter int NUM_OF_NODES    = 168,
   localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
   localparam int WH_BRAM_WIDTH  = DATA_WIDTH*NUM_FEATURES + NUM_NODE_WIDTH + 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start_i,
   input  logic [BRAM_ADDR_WIDTH-1:0]         total_words_i,
   input  logic                               wh_valid_i,
   output logic                               wh_ready_o,
   input  logic [DATA_WIDTH*NUM_FEATURES-1:0] wh_data_i,
   input  logic [NUM_NODE_WIDTH-1:0]          wh_num_nodes_i,
   output logic [WH_BRAM_WIDTH-1:0]           WH_BRAM_din,
   output logic                               WH_BRAM_ena,
   output logic                               WH_BRAM_wea,
   output logic [BRAM_ADDR_WIDTH-1:0]         WH_BRAM_addra,
   output logic                               wb_busy_o,
   output logic                               wb_done_o
`ifdef WB_STATS_EN
   ,
   output logic [NUM_NODE_WIDTH-1:0]          wb_subgraph_cnt_o
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [BRAM_ADDR_WIDTH-1:0] ONE_A = BRAM_ADDR_WIDTH'(1);
   localparam logic [NUM_NODE_WIDTH-1:0]  ONE_N = NUM_NODE_WIDTH'(1);

   logic [1:0]                 state_q, state_d;
   logic [BRAM_ADDR_WIDTH-1:0] left_q, left_d;    // words still to accept in this pass
   logic [BRAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;      // address of the next accepted word
   logic [NUM_NODE_WIDTH-1:0]  nn_q, nn_d;        // node count of the current sub-graph
   logic [NUM_NODE_WIDTH-1:0]  rem_q, rem_d;      // beats left in the current sub-graph
   logic                       first_q, first_d;  // next beat opens a new sub-graph
   logic [WH_BRAM_WIDTH-1:0]   din_q, din_d;
   logic                       en_q, en_d;
   logic [BRAM_ADDR_WIDTH-1:0] addra_q, addra_d;
   logic                       done_q, done_d;
   logic                       accept;
   logic [NUM_NODE_WIDTH-1:0]  beat_nn;
   logic [NUM_NODE_WIDTH-1:0]  beat_len;

   assign wh_ready_o = (state_q == S_WRITE);
   assign accept     = wh_valid_i && (state_q == S_WRITE);

   // Next state, sub-graph tagging and BRAM word formation
   always_comb begin
      state_d  = state_q;
      left_d   = left_q;
      ptr_d    = ptr_q;
      nn_d     = nn_q;
      rem_d    = rem_q;
      first_d  = first_q;
      din_d    = din_q;
      addra_d  = addra_q;
      en_d     = 1'b0;
      // done is delayed one cycle past DONE so it follows the final BRAM write edge
      done_d   = (state_q == S_DONE);
      beat_nn  = nn_q;
      beat_len = rem_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               left_d  = total_words_i;
               ptr_d   = '0;
               first_d = 1'b1;
               rem_d   = '0;
               state_d = (total_words_i == '0) ? S_DONE : S_WRITE;
            end
         end
         S_WRITE: begin
            if (accept) begin
               en_d    = 1'b1;
               addra_d = ptr_q;
               ptr_d   = ptr_q + ONE_A;
               left_d  = left_q - ONE_A;
               if (first_q) begin
                  beat_nn  = wh_num_nodes_i;
                  nn_d     = wh_num_nodes_i;
                  // a zero node count still occupies one beat
                  beat_len = (wh_num_nodes_i == '0) ? ONE_N : wh_num_nodes_i;
               end
               rem_d   = beat_len - ONE_N;
               first_d = (rem_d == '0);
               din_d   = {wh_data_i, beat_nn, first_q};
               if (left_q == ONE_A) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any pass in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         left_q  <= '0;
         ptr_q   <= '0;
         nn_q    <= '0;
         rem_q   <= '0;
         first_q <= 1'b0;
         din_q   <= '0;
         en_q    <= 1'b0;
         addra_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         ptr_q   <= ptr_d;
         nn_q    <= nn_d;
         rem_q   <= rem_d;
         first_q <= first_d;
         din_q   <= din_d;
         en_q    <= en_d;
         addra_q <= addra_d;
         done_q  <= done_d;
      end
   end

   assign WH_BRAM_din   = din_q;
   assign WH_BRAM_ena   = en_q;
   assign WH_BRAM_wea   = en_q;
   assign WH_BRAM_addra = addra_q;
   assign wb_busy_o     = (state_q == S_WRITE) || (state_q == S_DONE);
   assign wb_done_o     = done_q;

`ifdef WB_STATS_EN
   logic [NUM_NODE_WIDTH-1:0] sg_cnt_q, sg_cnt_d;

   // Count sub-graph start beats; cleared when a pass is started
   always_comb begin
      sg_cnt_d = sg_cnt_q;
      if ((state_q == S_IDLE) && start_i) begin
         sg_cnt_d = '0;
      end else if (accept && first_q) begin
         sg_cnt_d = sg_cnt_q + ONE_N;
      end
   end

   // Sub-graph counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sg_cnt_q <= '0;
      end else begin
         sg_cnt_q <= sg_cnt_d;
      end
   end

   assign wb_subgraph_cnt_o = sg_cnt_q;
`endif

endmodule

// File: tb/tb_wh_bram_writer.sv
// tb_wh_bram_writer
// Self-checking bench for wh_bram_writer: a table of passes with hand-derived
// write/start counts, hand-written corner sequences, and randomized passes,
// all compared word by word against a behavioural model of the packing rules.
// Optional macro WB_STATS_EN also checks wb_subgraph_cnt_o.
module tb_wh_bram_writer;

   localparam int AW  = 32;
   localparam int VW  = 128;
   localparam int NNW = 8;
   localparam int WBW = VW + NNW + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start_i;
   logic [AW-1:0]   total_words_i;
   logic            wh_valid_i;
   logic            wh_ready_o;
   logic [VW-1:0]   wh_data_i;
   logic [NNW-1:0]  wh_num_nodes_i;
   logic [WBW-1:0]  WH_BRAM_din;
   logic            WH_BRAM_ena;
   logic            WH_BRAM_wea;
   logic [AW-1:0]   WH_BRAM_addra;
   logic            wb_busy_o;
   logic            wb_done_o;
`ifdef WB_STATS_EN
   logic [NNW-1:0]  wb_subgraph_cnt_o;
`endif

   wh_bram_writer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .total_words_i  (total_words_i),
      .wh_valid_i     (wh_valid_i),
      .wh_ready_o     (wh_ready_o),
      .wh_data_i      (wh_data_i),
      .wh_num_nodes_i (wh_num_nodes_i),
      .WH_BRAM_din    (WH_BRAM_din),
      .WH_BRAM_ena    (WH_BRAM_ena),
      .WH_BRAM_wea    (WH_BRAM_wea),
      .WH_BRAM_addra  (WH_BRAM_addra),
      .wb_busy_o      (wb_busy_o),
`ifdef WB_STATS_EN
      .wb_done_o      (wb_done_o),
      .wb_subgraph_cnt_o (wb_subgraph_cnt_o)
`else
      .wb_done_o      (wb_done_o)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // observed traffic
   logic [AW-1:0]  wr_addr[$];
   logic [WBW-1:0] wr_din[$];
   int             wr_cyc[$];
   int             acc_cyc[$];
   int             done_cnt = 0;
   int             done_cyc = 0;
   int             ew_bad   = 0;
   int             start_cyc;
   int             pass_dones;

   // stimulus beats for the current pass
   logic [VW-1:0]  beat_data [64];
   logic [NNW-1:0] beat_nn   [64];
   int             n_beats;

   // expected words
   logic [WBW-1:0] exp_din[$];

   typedef struct {
      int total;
      int nn;
      int mode;
      int exp_writes;
      int exp_starts;
   } vec_t;
   vec_t vecs[6];

   // Port-a monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (WH_BRAM_ena === 1'b1) begin
         wr_addr.push_back(WH_BRAM_addra);
         wr_din.push_back(WH_BRAM_din);
         wr_cyc.push_back(cyc);
      end
      if (WH_BRAM_ena !== WH_BRAM_wea) ew_bad++;
      if (wb_done_o === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_beat(input int i, input bit v);
      wh_valid_i = v;
      if (v) begin
         wh_data_i      = beat_data[i];
         wh_num_nodes_i = beat_nn[i];
      end else begin
         wh_data_i      = {$urandom, $urandom, $urandom, $urandom};
         wh_num_nodes_i = NNW'($urandom);
      end
   endtask

   // Expected words: a sub-graph opens when the previous one has used up
   // max(nn,1) beats; its first beat latches nn, all its beats carry nn.
   task automatic build_model(input int total);
      int left_in_sg;
      logic [NNW-1:0] cur;
      logic f;
      exp_din.delete();
      left_in_sg = 0;
      cur = '0;
      for (int i = 0; i < total; i++) begin
         if (left_in_sg == 0) begin
            f = 1'b1;
            cur = beat_nn[i];
            left_in_sg = (beat_nn[i] == 0) ? 1 : int'(beat_nn[i]);
         end else begin
            f = 1'b0;
         end
         exp_din.push_back({beat_data[i], cur, f});
         left_in_sg--;
      end
   endtask

   task automatic clear_obs();
      wr_addr.delete();
      wr_din.delete();
      wr_cyc.delete();
      acc_cyc.delete();
   endtask

   // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random valid
   task automatic run_pass(input int total, input int mode);
      int idx, budget, d0;
      bit acc, want;
      clear_obs();
      d0 = done_cnt;
      start_i = 1'b1;
      total_words_i = AW'(total);
      drive_beat(0, n_beats > 0);
      @(negedge clk);
      start_cyc = cyc;
      if (wh_valid_i && wh_ready_o) acc_cyc.push_back(cyc);
      @(posedge clk); #1;
      start_i = 1'b0;
      total_words_i = $urandom;
      check("busy_after_start", wb_busy_o, 1'b1);
      idx = 0;
      budget = 0;
      while (done_cnt == d0 && budget < 400) begin
         case (mode)
            0:       want = 1'b1;
            1:       want = (budget % 2 == 1);
            default: want = ($urandom_range(0, 99) < 65);
         endcase
         drive_beat(idx, want && (idx < n_beats));
         @(negedge clk);
         acc = wh_valid_i && wh_ready_o;
         if (acc) acc_cyc.push_back(cyc);
         @(posedge clk); #1;
         if (acc) idx++;
         budget++;
      end
      // offer the next beat while idle: it must not be taken
      drive_beat(idx, idx < n_beats);
      repeat (3) begin
         @(negedge clk);
         if (wh_valid_i && wh_ready_o) acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      drive_beat(0, 1'b0);
      pass_dones = done_cnt - d0;
      $display("pass total=%0d mode=%0d writes=%0d accepts=%0d dones=%0d",
               total, mode, wr_din.size(), acc_cyc.size(), pass_dones);
   endtask

   task automatic check_pass(input int total);
      int n;
      build_model(total);
      check("write_count", wr_din.size(), total);
      check("accept_count", acc_cyc.size(), total);
      n = (wr_din.size() < total) ? wr_din.size() : total;
      for (int i = 0; i < n; i++) begin
         check("addr", wr_addr[i], AW'(i));
         check("din", wr_din[i], exp_din[i]);
         if (i < acc_cyc.size()) check("write_latency", wr_cyc[i], acc_cyc[i] + 1);
      end
      check("done_pulses", pass_dones, 1);
      if (total == 0)
         check("done_time_empty", done_cyc, start_cyc + 2);
      else if (wr_cyc.size() > 0)
         check("done_time", done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
      check("busy_idle", wb_busy_o, 1'b0);
      check("ready_idle", wh_ready_o, 1'b0);
   endtask

   function automatic logic [WBW-1:0] got_din(input int i);
      if (i < wr_din.size()) return wr_din[i];
      return '0;
   endfunction

   function automatic int count_starts();
      int s = 0;
      foreach (wr_din[i]) if (wr_din[i][0]) s++;
      return s;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      logic [7:0] spec_vals [10];
      int total;

      // table: {total, nn, mode, writes, sub-graph starts}
      vecs[0] = '{4, 2, 1, 4, 2};
      vecs[1] = '{3, 0, 0, 3, 3};
      vecs[2] = '{5, 1, 2, 5, 5};
      vecs[3] = '{7, 3, 2, 7, 3};
      vecs[4] = '{1, 9, 0, 1, 1};
      vecs[5] = '{0, 4, 0, 0, 0};

      // reset with valid held high
      rst_n = 1'b0;
      start_i = 1'b0;
      total_words_i = '0;
      drive_beat(0, 1'b0);
      wh_valid_i = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_din", WH_BRAM_din, '0);
      check("rst_ena", WH_BRAM_ena, 1'b0);
      check("rst_wea", WH_BRAM_wea, 1'b0);
      check("rst_addra", WH_BRAM_addra, '0);
      check("rst_busy", wb_busy_o, 1'b0);
      check("rst_done", wb_done_o, 1'b0);
      check("rst_ready", wh_ready_o, 1'b0);
      check("rst_no_write", wr_din.size(), 0);
`ifdef WB_STATS_EN
      check("rst_sg_cnt", wb_subgraph_cnt_o, '0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      wh_valid_i = 1'b0;
      @(posedge clk); #1;

      // two sub-graphs of 5 nodes in a 10-word pass
      spec_vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1};
      n_beats = 11;
      for (int i = 0; i < 11; i++) begin
         v = (i < 10) ? spec_vals[i] : 8'd9;
         beat_data[i] = {16{v}};
         beat_nn[i] = (i == 0 || i == 5) ? 8'd5 : 8'd3;
      end
      run_pass(10, 0);
      check_pass(10);
      check("two_sg_addr0", got_din(0), {{16{8'd1}}, 8'd5, 1'b1});
      check("two_sg_addr4", got_din(4), {{16{8'd5}}, 8'd5, 1'b0});
      check("two_sg_addr5_first", got_din(5) & WBW'(1), WBW'(1));
      check("two_sg_addr9", got_din(9), {{16{8'd1}}, 8'd5, 1'b0});

      // table-driven passes
      for (int r = 0; r < 6; r++) begin
         n_beats = vecs[r].total + 2;
         for (int i = 0; i < n_beats; i++) begin
            beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
            beat_nn[i] = NNW'(vecs[r].nn);
         end
         run_pass(vecs[r].total, vecs[r].mode);
         check_pass(vecs[r].total);
         check("table_writes", wr_din.size(), vecs[r].exp_writes);
         check("table_starts", count_starts(), vecs[r].exp_starts);
`ifdef WB_STATS_EN
         check("table_sg_cnt", wb_subgraph_cnt_o, NNW'(vecs[r].exp_starts));
`endif
      end

      // reset in the middle of a pass, then a fresh 2-word pass
      clear_obs();
      n_beats = 6;
      for (int i = 0; i < 6; i++) begin
         beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
         beat_nn[i] = 8'd2;
      end
      begin
         int d0;
         d0 = done_cnt;
         start_i = 1'b1;
         total_words_i = 6;
         @(posedge clk); #1;
         start_i = 1'b0;
         for (int k = 0; k < 3; k++) begin
            drive_beat(k, 1'b1);
            @(posedge clk); #1;
         end
         rst_n = 1'b0;
         drive_beat(3, 1'b1);
         repeat (3) @(posedge clk);
         #1;
         rst_n = 1'b1;
         drive_beat(0, 1'b0);
         repeat (2) @(posedge clk);
         @(negedge clk);
         check("midrst_writes", wr_din.size(), 3);
         check("midrst_no_done", done_cnt - d0, 0);
         check("midrst_busy", wb_busy_o, 1'b0);
         check("midrst_ena", WH_BRAM_ena, 1'b0);
         $display("mid-pass reset writes=%0d", wr_din.size());
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
      n_beats = 4;
      run_pass(2, 0);
      check_pass(2);

      // randomized passes
      for (int r = 0; r < 8; r++) begin
         total = $urandom_range(1, 24);
         n_beats = total + 1;
         for (int i = 0; i < n_beats; i++) begin
            beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
            beat_nn[i] = NNW'($urandom_range(0, 6));
         end
         run_pass(total, 2);
         check_pass(total);
      end

      check("ena_equals_wea", ew_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
